serial_sub: RTL

SERIAL_SUB -- requirements
Module: serial_sub

---
 rtl/serial_sub.sv | 118 +++++++++++
 1 files changed

// File: rtl/serial_sub.sv
// Nibble-serial unsigned subtractor: one 4-bit carry-lookahead slice per cycle,
// borrow rippled between slices through a register, results registered on completion.
module serial_sub #(
  parameter int NIBBLES = 4
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Start,
  input  logic [4*NIBBLES-1:0]   A,
  input  logic [4*NIBBLES-1:0]   B,
  input  logic                   Bin,
  output logic                   Busy,
  output logic                   Done,
  output logic [4*NIBBLES-1:0]   D,
  output logic                   Bout,
  output logic                   Z
);
  // state | meaning
  // IDLE  | waiting for Start; operands latched on accept
  // RUN   | one slice per cycle, index 0 .. NIBBLES-1
  // DONE  | results valid, Done pulse, back to IDLE
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_q, b_q, acc, acc_nxt;
  logic            borrow;
  logic [IW-1:0]   idx;
  logic [3:0]      a_sl, b_sl, bb, g, p, c, sum;
  logic            cout;

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = RUN;
      RUN:     if (idx == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state != IDLE);
    Done = (state == DONE);
  end

  // Slice select and write-back into the partial-result register
  always_comb begin
    a_sl    = 4'h0;
    b_sl    = 4'h0;
    acc_nxt = acc;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        a_sl = a_q[i*4 +: 4];
        b_sl = b_q[i*4 +: 4];
        acc_nxt[i*4 +: 4] = sum;
      end
    end
  end

  // A + ~B + ~borrow through a 4-bit generate/propagate network
  always_comb begin
    bb   = ~b_sl;
    g    = a_sl & bb;
    p    = a_sl ^ bb;
    c[0] = ~borrow;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (&p & c[0]);
    sum  = p ^ c;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      borrow <= 1'b0;
      idx    <= '0;
      D      <= '0;
      Bout   <= 1'b0;
      Z      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            a_q    <= A;
            b_q    <= B;
            borrow <= Bin;
            idx    <= '0;
            acc    <= '0;
          end
        end
        RUN: begin
          acc    <= acc_nxt;
          borrow <= ~cout;
          idx    <= idx + 1'b1;
          if (idx == LAST) begin
            D    <= acc_nxt;
            Bout <= ~cout;
            Z    <= (acc_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
